// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sub_state_t;

  localparam int SUB_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/half_subtractor.sv
// Half subtractor cell: diff = a ^ b, borrow = ~a & b.
// Ports: a, b (in); diff, borrow (out). Gate-level structure.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  logic a_n;

  xor g_diff (diff, a, b);
  not g_inv  (a_n, a);
  and g_brw  (borrow, a_n, b);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, diff = a - b, one bit per clock, LSB first.
// Ports: clk, rst, start, a, b (in); busy, done, diff, borrow_out (out).
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);

  sub_state_t state;
  sub_state_t state_nx;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nx;
  logic [CW-1:0]    cnt;
  logic             brw;

  logic d1;
  logic b1;
  logic d;
  logic b2;
  logic brw_nx;
  logic last;
  logic accept;

  half_subtractor u_hs1 (
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .diff   (d1),
    .borrow (b1)
  );

  half_subtractor u_hs2 (
    .a      (d1),
    .b      (brw),
    .diff   (d),
    .borrow (b2)
  );

  assign brw_nx = b1 | b2;
  assign last   = (cnt == CW'(WIDTH - 1));
  // New bit enters at the MSB; the oldest bit falls off the LSB.
  assign res_nx = WIDTH'({d, res_sr} >> 1);

  // A new request is only taken when not mid-operation.
  assign accept = start && (state != RUN);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      brw        <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      brw  <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nx;
      brw    <= brw_nx;
      cnt    <= cnt + 1'b1;
      if (last) begin
        diff       <= res_nx;
        borrow_out <= brw_nx;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8).
// Directed table, hand-written corner sequences, random ops vs model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int n_pass;
  int n_total;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         br;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain modular subtraction and unsigned compare.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    return W'(x - y);
  endfunction

  function automatic logic ref_brw(input logic [W-1:0] x,
                                   input logic [W-1:0] y);
    return x < y;
  endfunction

  // Wait (at negedges) for done; returns negedges counted.
  task automatic wait_done(output int lat, output int nbusy,
                           output bit seen);
    lat   = 1;
    nbusy = 0;
    seen  = 0;
    while (!seen && lat < 40) begin
      if (busy) nbusy++;
      if (done) seen = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] av,
                        input logic [W-1:0] bv,
                        input string tag);
    int lat;
    int nbusy;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    wait_done(lat, nbusy, seen);
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'd9);
    chk({tag, " busy_cycles"}, 32'(nbusy), 32'd8);
    chk({tag, " diff"}, 32'(diff), 32'(ref_diff(av, bv)));
    chk({tag, " borrow"}, 32'(borrow_out), 32'(ref_brw(av, bv)));
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int nbusy;
    int ndone;
    bit seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    n_pass  = 0;
    n_total = 0;

    vecs[0] = '{8'h35, 8'h12, 8'h23, 1'b0};
    vecs[1] = '{8'h12, 8'h35, 8'hDD, 1'b1};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h7F, 8'h01, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset diff", 32'(diff), 32'd0);
    chk("reset borrow", 32'(borrow_out), 32'd0);
    rst = 1'b0;

    // Directed table, checked against fixed constants.
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl_diff", i), 32'(diff), 32'(vecs[i].d));
      chk($sformatf("vec%0d tbl_brw", i), 32'(borrow_out),
          32'(vecs[i].br));
    end

    // Result holds through idle.
    repeat (3) @(negedge clk);
    chk("hold diff", 32'(diff), 32'h01);

    // start raised mid-run must be ignored.
    @(negedge clk);
    start = 1'b1;
    a     = 8'h50;
    b     = 8'h20;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) ndone++;
      if (done) begin
        chk("ignore diff", 32'(diff), 32'h30);
        chk("ignore borrow", 32'(borrow_out), 32'd0);
      end
      @(negedge clk);
    end
    chk("ignore done_count", 32'(ndone), 32'd1);

    // Back-to-back with start held through the DONE cycle.
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h01;
    @(negedge clk);
    wait_done(lat, nbusy, seen);
    chk("b2b first_seen", 32'(seen), 32'd1);
    chk("b2b first_diff", 32'(diff), 32'h0F);
    chk("b2b first_brw", 32'(borrow_out), 32'd0);
    a = 8'h01;
    b = 8'h10;
    @(negedge clk);
    a = 8'hC3;
    b = 8'h3C;
    start = 1'b0;
    wait_done(lat, nbusy, seen);
    chk("b2b second_seen", 32'(seen), 32'd1);
    chk("b2b second_lat", 32'(lat), 32'd9);
    chk("b2b second_diff", 32'(diff), 32'hF1);
    chk("b2b second_brw", 32'(borrow_out), 32'd1);
    @(negedge clk);

    // Reset in the 4th RUN cycle aborts the operation.
    start = 1'b1;
    a     = 8'h77;
    b     = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst pre busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst async busy", 32'(busy), 32'd0);
    chk("rst async done", 32'(done), 32'd0);
    chk("rst async diff", 32'(diff), 32'd0);
    chk("rst async borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    chk("rst no_done", 32'(ndone), 32'd0);
    run_op(8'h9A, 8'h0B, "post_rst");

    // Random operations against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b, one bit per clock, LSB first.
- Built from two half_subtractor cells; this is the subtraction counterpart of the team's half-adder arithmetic primitives.
- Sits in the datapath as a small-area ALU helper with a start/done handshake.
- Trades latency (WIDTH+1 cycles) for a single-bit datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when state is IDLE or DONE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; diff/borrow_out valid.
- diff  output  WIDTH  registered result (a - b) mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 if and only if a < b (unsigned).

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; busy = 0, done = 0, diff = 0, borrow_out = 0; internal shift registers, borrow flop and counter cleared.
- States: IDLE, RUN, DONE.
  - IDLE: busy = 0, done = 0. If start = 1 at an edge: load a_sr <= a, b_sr <= b, brw <= 0, cnt <= 0; go to RUN.
  - RUN: busy = 1. Each edge, take ai = a_sr[0], bi = b_sr[0].
    - Half-subtractor 1: d1 = ai ^ bi, b1 = ~ai & bi.
    - Half-subtractor 2: d = d1 ^ brw, b2 = ~d1 & brw.
    - brw <= b1 | b2.
    - Shift a_sr, b_sr right by one; shift d into the MSB of res_sr; cnt <= cnt + 1.
    - On the edge where cnt == WIDTH-1: diff <= final res_sr (including this bit), borrow_out <= b1 | b2; go to DONE.
  - DONE: done = 1 for exactly this one cycle; busy = 0. If start = 1: accept as in IDLE (back-to-back) and go to RUN. Otherwise go to IDLE.
- Latency: start accepted at edge E0; done is high in the cycle following edge E0 + WIDTH. Maximum throughput is one operation per WIDTH+1 cycles.
- start during RUN is ignored: no effect on the operation or its operands.
- diff and borrow_out change only on the RUN->DONE transition. They hold their values through IDLE and the next RUN until the next completion.
- a and b are don't-care except on the accepting edge.
- Reset asserted mid-RUN aborts the operation: outputs return to their reset values and no done pulse is produced.
- Counter width: $clog2(WIDTH+1); counter wrap is never reached.
- WIDTH = 1: exactly one RUN cycle; diff = a ^ b, borrow_out = ~a & b.

Decomposition:
- Package sub_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t.
  - Constant SUB_DEFAULT_WIDTH = 8.
- Sub-module half_subtractor (inputs a, b; outputs diff = a^b, borrow = ~a&b), structural gate style. Instantiated twice to form the full-subtractor bit cell.
- Top level holds the FSM, shift registers, counter and output registers.

Test Plan (WIDTH = 8):
- Basic: a = 0x35, b = 0x12, start pulse. Required:
  - busy high for 8 cycles;
  - done pulse 9 cycles after the accepting edge;
  - diff = 0x23, borrow_out = 0.
- Negative result: a = 0x12, b = 0x35 -> diff = 0xDD, borrow_out = 1. Also a = 0x00, b = 0x01 -> diff = 0xFF, borrow_out = 1.
- Equal and extreme operands:
  - a = 0xFF, b = 0xFF -> diff = 0x00, borrow_out = 0.
  - a = 0x80, b = 0x7F -> diff = 0x01, borrow_out = 0.
- start ignored during RUN: start a = 0x50, b = 0x20; mid-RUN, raise start with a = 0xAA, b = 0x55. Required: exactly one done, diff = 0x30, borrow_out = 0.
- Back-to-back: hold start high with a = 0x10, b = 0x01, then change to a = 0x01, b = 0x10 during the DONE cycle. Required:
  - first done: diff = 0x0F, borrow_out = 0;
  - second done exactly 9 cycles later: diff = 0xF1, borrow_out = 1.
- Reset mid-operation: assert rst at cycle 4 of RUN. Required:
  - busy, done, diff, borrow_out = 0 immediately (asynchronously);
  - no done pulse afterwards;
  - a new start after reset release completes normally.
